// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the fetch/data memory arbiter.
// Holds the word width, the response-owner encoding and the starvation counter width.
package mem_arbiter_pkg;

  localparam int WORD_LEN     = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_IFETCH = 2'd1,
    OWNER_DLOAD  = 2'd2
  } owner_e;

  // Who gets the read data returning next cycle; stores never produce a response.
  function automatic owner_e next_owner(input logic grant_i, input logic grant_d, input logic wen);
    owner_e owner;
    if (grant_i) begin
      owner = OWNER_IFETCH;
    end else if (grant_d && !wen) begin
      owner = OWNER_DLOAD;
    end else begin
      owner = OWNER_NONE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data has fixed priority; a saturating starvation counter forces a fetch grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  input  logic [WORD_LEN-1:0] i_req_addr,
  output logic                i_req_ready,
  input  logic                i_flush,
  output logic                i_rsp_valid,
  output logic [WORD_LEN-1:0] i_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_wen,
  input  logic [WORD_LEN-1:0] d_req_addr,
  input  logic [WORD_LEN-1:0] d_req_wdata,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [WORD_LEN-1:0] d_rsp_data,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE      = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};

  owner_e                  r_owner;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_force_i;
  logic                    w_grant_i;
  logic                    w_grant_d;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    w_force_i = 1'b0;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (rst_n) begin
      w_force_i = i_req_valid && (r_starve_cnt == STARVE_MAX_C);
      if (w_force_i) begin
        w_grant_i = 1'b1;
      end else if (d_req_valid) begin
        w_grant_d = 1'b1;
      end else if (i_req_valid) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
      end
    end else begin
      w_force_i = 1'b0;
    end
  end

  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  // Memory request mux: the granted requester drives the port, idle drives zeros.
  always_comb begin
    mem_addr  = {WORD_LEN{1'b0}};
    mem_wdata = {WORD_LEN{1'b0}};
    mem_wen   = 1'b0;
    if (w_grant_i) begin
      mem_addr = i_req_addr;
    end else if (w_grant_d) begin
      mem_addr  = d_req_addr;
      mem_wdata = d_req_wdata;
      mem_wen   = d_req_wen;
    end else begin
      mem_addr = {WORD_LEN{1'b0}};
    end
  end

  // Response owner and starvation counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWNER_NONE;
      r_starve_cnt <= {STARVE_CNT_W{1'b0}};
    end else begin
      r_owner <= next_owner(w_grant_i, w_grant_d, d_req_wen);
      if (!i_req_valid || w_grant_i) begin
        r_starve_cnt <= {STARVE_CNT_W{1'b0}};
      end else if (r_starve_cnt != STARVE_MAX_C) begin
        r_starve_cnt <= r_starve_cnt + CNT_ONE;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end
  end

  // Read data returns one cycle after the grant; a flush only hides the fetch copy.
  always_comb begin
    i_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    case (r_owner)
      OWNER_IFETCH: i_rsp_valid = !i_flush;
      OWNER_DLOAD:  d_rsp_valid = 1'b1;
      OWNER_NONE:   i_rsp_valid = 1'b0;
      default:      d_rsp_valid = 1'b0;
    endcase
  end

  assign i_rsp_data = mem_rdata;
  assign d_rsp_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_flush;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_req_valid;
  logic        d_req_wen;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_wen(d_req_wen), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream synchronous memory: 1-cycle read latency, word addressed.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        iq[$];
  rsp_t        dq[$];
  logic [31:0] ref_mem [0:255];
  int          denied;
  logic        flush_plan;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive, predict grants from the arbitration rules, queue responses.
  task automatic step(input logic iv, input logic [31:0] ia, input logic dv, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic fl_next);
    logic        force_i;
    logic        gi;
    logic        gd;
    logic [31:0] ea;
    @(posedge clk);
    #2;
    rst_n       = 1'b1;
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_wen   = dw;
    d_req_addr  = da;
    d_req_wdata = dd;
    i_flush     = flush_plan;
    #1;
    force_i = iv && (denied == STARVE_MAX);
    gi = force_i || (iv && !dv);
    gd = dv && !force_i;
    ea = gi ? ia : (gd ? da : 32'd0);
    chk("i_req_ready", 32'(i_req_ready), 32'(gi));
    chk("d_req_ready", 32'(d_req_ready), 32'(gd));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wen", 32'(mem_wen), 32'(gd && dw));
    if (gd && dw) begin
      chk("mem_wdata", mem_wdata, dd);
      ref_mem[da[9:2]] = dd;
    end
    if (gd && !dw) dq.push_back('{cyc + 1, ref_mem[da[9:2]]});
    if (gi && !fl_next) iq.push_back('{cyc + 1, ref_mem[ia[9:2]]});
    if (!iv || gi) denied = 0;
    else if (denied < STARVE_MAX) denied = denied + 1;
    flush_plan = fl_next;
  endtask

  // Response monitor: every presented response must match the queue head due this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_rsp_valid) begin
        if (iq.size() == 0 || iq[0].due != cyc) begin
          chk("i_rsp_unexpected", 32'(i_rsp_valid), 32'd0);
        end else begin
          chk("i_rsp_data", i_rsp_data, iq[0].data);
          void'(iq.pop_front());
        end
      end else if (iq.size() != 0 && iq[0].due == cyc) begin
        chk("i_rsp_missing", 32'(i_rsp_valid), 32'd1);
        void'(iq.pop_front());
      end
      if (d_rsp_valid) begin
        if (dq.size() == 0 || dq[0].due != cyc) begin
          chk("d_rsp_unexpected", 32'(d_rsp_valid), 32'd0);
        end else begin
          chk("d_rsp_data", d_rsp_data, dq[0].data);
          void'(dq.pop_front());
        end
      end else if (dq.size() != 0 && dq[0].due == cyc) begin
        chk("d_rsp_missing", 32'(d_rsp_valid), 32'd1);
        void'(dq.pop_front());
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0010;
    d_req_valid = 1'b1;
    d_req_wen   = 1'b1;
    d_req_addr  = 32'h0000_0020;
    d_req_wdata = 32'hFFFF_FFFF;
    i_flush     = 1'b0;
    denied      = 0;
    flush_plan  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    // Reset held with both requesters active
    repeat (2) @(posedge clk);
    #3;
    chk("rst_i_req_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_req_ready", 32'(d_req_ready), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);

    // Release: data wins the first cycle
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0);
    chk("release_d_first", 32'(d_req_ready), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Lone fetch of word 4
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Continuous contention: fetch forced every fifth cycle
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'($urandom_range(0, 1023)), 1'b1, 1'b0, 32'($urandom_range(0, 1023)), 32'd0, 1'b0);
      chk("starve_pattern", 32'(i_req_ready), 32'((k % 5) == 4));
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Store then load of the same word
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    chk("load_after_store_wen", 32'(mem_wen), 32'd0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Flushed fetch followed by an un-flushed one
    step(1'b1, 32'h44, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 32'h48, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reset pulse while a load response is in flight
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    i_flush     = 1'b0;
    #1;
    rst_n = 1'b1;
    iq.delete();
    dq.delete();
    denied     = 0;
    flush_plan = 1'b0;
    #1;
    chk("midrst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("midrst_owner", 32'(dut.r_owner), 32'(OWNER_NONE));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 9) < 7), 32'($urandom_range(0, 63)),
           1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 3),
           32'($urandom_range(0, 63)), 32'($urandom), 1'($urandom_range(0, 9) < 2));
    end

    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
